key_out_stream: RTL
===================

Name: key_out_stream

Overview:
- Downstream consumer of the keypoint shift buffer; sits between the buffer and the off-chip/matcher interface.
- Captures the keypoint record the buffer retires on each hit cycle and discards empty (zero-score) slots.
- Queues valid keypoints in a small FIFO, enforces a per-frame key cap, and streams records out on a valid/ready handshake.
- Closes each frame with a single end-of-frame marker beat.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- MAX_KEYS, 500, maximum keypoints accepted per frame; must be ≤ 1023.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse; opens a frame
- i_frame_end  in  1  one-cycle pulse; closes a frame
- i_hit  in  1  buffer retires its tail entry this cycle
- i_sin  in  12  tail orientation sine
- i_cos  in  12  tail orientation cosine
- i_coor_x  in  10  tail x
- i_coor_y  in  10  tail y
- i_score  in  8  tail score; 0 means empty slot
- i_ready  in  1  sink ready
- o_valid  out  1  output beat valid
- o_last  out  1  beat is the end-of-frame marker
- o_sin  out  12  output field
- o_cos  out  12  output field
- o_coor_x  out  10  output field
- o_coor_y  out  10  output field
- o_score  out  8  output field
- o_key_cnt  out  10  keys accepted in the current or last frame
- o_overflow  out  1  sticky; a key was dropped because the FIFO was full

Behaviour:
- Clock/reset: one clock, i_clk. i_rst_n is asynchronous, active-low.
- Reset values: state IDLE; FIFO empty; o_valid=0, o_last=0, all data outputs 0, o_key_cnt=0, o_overflow=0.
- FSM states: IDLE, COLLECT, FLUSH, MARK.
  - IDLE: i_frame_start -> COLLECT. This clears o_key_cnt and o_overflow; FIFO contents are kept.
  - COLLECT: i_frame_end -> FLUSH. i_frame_start in COLLECT restarts the frame: clears the counters and stays in COLLECT. If start and end pulse together, end wins.
  - FLUSH: waits until the FIFO is empty -> MARK. i_frame_start is ignored.
  - MARK: drives o_valid=1, o_last=1, all data fields 0. The handshake (o_valid & i_ready) -> IDLE.
- Accept rule, evaluated only in COLLECT: i_hit & (i_score ≥ thresh) & (o_key_cnt < MAX_KEYS).
  - Accepted and FIFO not full: write the record; o_key_cnt += 1.
  - Accepted and FIFO full with no pop this cycle: drop the record; set o_overflow; o_key_cnt unchanged.
  - Full with a simultaneous pop: the write succeeds.
  - A hit that coincides with i_frame_end is still evaluated under COLLECT rules.
- Out-of-state hits: i_hit outside COLLECT, or once the cap is reached, is silently ignored.
- FIFO timing: first-word fall-through from registered storage.
  - A record written in cycle N is visible on o_valid at cycle N+1; there is no same-cycle bypass.
  - A push and pop on an empty FIFO cannot occur together.
- Output handshake:
  - While o_valid & !i_ready, all outputs hold stable.
  - Data beats carry o_last=0. o_valid is never deasserted without a transfer.
- Counter: o_key_cnt saturates at MAX_KEYS and holds through IDLE until the next frame start.
- Pointers: read/write pointers are log2(DEPTH)+1 bits with MSB wrap for full/empty detection.
- Mid-frame reset: returns immediately to the reset state. Any in-flight beat is lost; the sink must tolerate a missing o_last.

Optional Feature:
- Macro: KEY_SCORE_THRESH_EN.
- Defined: adds input port i_thresh [7:0], sampled every cycle; thresh = i_thresh. i_thresh = 0 is treated as 1, so empty slots are never accepted.
- Undefined: no port; thresh is the constant 1, so every nonzero-score record is accepted.

Decomposition:
- Shared package vo_key_pkg:
  - typedef key_t: packed struct {sin[11:0], cos[11:0], x[9:0], y[9:0], score[7:0]}, 52 bits.
  - Field-width localparams.
  - Enum kos_state_t {IDLE, COLLECT, FLUSH, MARK}.
- Sub-module key_fifo: parameterised sync FWFT FIFO of key_t.
  - Ports: push, pop, full, empty, din, dout.
  - Instantiated once; the FSM, accept logic and counters stay in key_out_stream.

Test Plan:
- Basic frame: frame_start; 3 hits with scores 5, 0, 9 and i_ready=1 -> exactly 2 data beats (scores 5, 9), each one cycle after its hit; then one o_last beat; o_key_cnt=2.
- Back-pressure: i_ready=0, 10 hits with score 7 (DEPTH=8) -> 8 stored; o_overflow=1; o_key_cnt=8. Release i_ready -> 8 beats with stable data while stalled, in order, then the marker after frame_end.
- Full with simultaneous pop: fill 8 entries, then a hit in the same cycle as a handshake -> no drop; o_overflow stays 0; count = 9.
- Cap: MAX_KEYS=4, 6 valid hits -> 4 beats; o_key_cnt=4.
- Ordering: frame_end while FIFO holds 3 -> marker only after the 3rd beat. Reset asserted during FLUSH -> o_valid=0 asynchronously; state IDLE.
- Threshold (KEY_SCORE_THRESH_EN): i_thresh=10, scores 9, 10, 200 -> beats for scores 10 and 200 only. i_thresh=0, score 0 -> no beat.

Source files
------------

// File: rtl/key_out_stream_pkg.sv
// Shared types for the keypoint output stream: the 52-bit keypoint record,
// its field widths, the stream controller state encoding and a record packer.
package vo_key_pkg;

  localparam int SIN_W   = 12;
  localparam int COS_W   = 12;
  localparam int X_W     = 10;
  localparam int Y_W     = 10;
  localparam int SCORE_W = 8;
  localparam int KEY_W   = SIN_W + COS_W + X_W + Y_W + SCORE_W;
  localparam int CNT_W   = 10;

  typedef struct packed {
    logic [SIN_W-1:0]   sin;
    logic [COS_W-1:0]   cos;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [SCORE_W-1:0] score;
  } key_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    MARK    = 2'd3
  } kos_state_t;

  // Assemble a keypoint record from the buffer tail fields.
  function automatic key_t f_key_pack(
    input logic [SIN_W-1:0]   sin,
    input logic [COS_W-1:0]   cos,
    input logic [X_W-1:0]     x,
    input logic [Y_W-1:0]     y,
    input logic [SCORE_W-1:0] score
  );
    key_t k;
    k.sin   = sin;
    k.cos   = cos;
    k.x     = x;
    k.y     = y;
    k.score = score;
    return k;
  endfunction

endpackage

// File: rtl/key_out_stream_fifo.sv
// key_fifo: synchronous first-word fall-through FIFO of keypoint records.
// The head entry is read straight out of registered storage, so a record
// written in one cycle is visible on dout the next cycle (no bypass).
// Pointers carry one extra MSB so full and empty can be told apart.
module key_fifo
  import vo_key_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  key_t i_din,
  output key_t o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  key_t          r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A full FIFO may still take a write when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | i_pop);
  assign w_do_pop  = i_pop & ~w_empty;

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  // Advance the read and write pointers on accepted pushes and pops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Store the incoming record at the write slot; storage needs no reset
  // because an empty FIFO never exposes its contents downstream.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/key_out_stream.sv
// key_out_stream: captures keypoints retired by the shift buffer, drops
// empty slots, queues them in key_fifo, caps the keys per frame and streams
// them on a valid/ready interface, closing each frame with one marker beat.
// Optional build macro KEY_SCORE_THRESH_EN adds the i_thresh score threshold
// input; without it every nonzero-score record is accepted.
module key_out_stream
  import vo_key_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int MAX_KEYS = 500
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
`ifdef KEY_SCORE_THRESH_EN
  input  logic [SCORE_W-1:0] i_thresh,
`endif
  input  logic               i_frame_start,
  input  logic               i_frame_end,
  input  logic               i_hit,
  input  logic [SIN_W-1:0]   i_sin,
  input  logic [COS_W-1:0]   i_cos,
  input  logic [X_W-1:0]     i_coor_x,
  input  logic [Y_W-1:0]     i_coor_y,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_ready,
  output logic               o_valid,
  output logic               o_last,
  output logic [SIN_W-1:0]   o_sin,
  output logic [COS_W-1:0]   o_cos,
  output logic [X_W-1:0]     o_coor_x,
  output logic [Y_W-1:0]     o_coor_y,
  output logic [SCORE_W-1:0] o_score,
  output logic [CNT_W-1:0]   o_key_cnt,
  output logic               o_overflow
);

  kos_state_t         r_state;
  logic               r_last;
  logic [CNT_W-1:0]   r_key_cnt;
  logic               r_overflow;

  logic [SCORE_W-1:0] w_thresh;
  key_t               w_in_key;
  key_t               w_head_key;
  key_t               w_out_key;
  logic               w_full;
  logic               w_empty;
  logic               w_fifo_valid;
  logic               w_pop;
  logic               w_cap_ok;
  logic               w_accept;
  logic               w_push;
  logic               w_drop;

`ifdef KEY_SCORE_THRESH_EN
  // A zero threshold is lifted to 1 so empty slots can never pass.
  assign w_thresh = (i_thresh == 8'd0) ? 8'd1 : i_thresh;
`else
  assign w_thresh = 8'd1;
`endif

  assign w_in_key     = f_key_pack(i_sin, i_cos, i_coor_x, i_coor_y, i_score);
  assign w_fifo_valid = ~w_empty;
  assign w_pop        = w_fifo_valid & i_ready;
  assign w_cap_ok     = (r_key_cnt < CNT_W'(MAX_KEYS));
  assign w_accept     = (r_state == COLLECT) & i_hit &
                        (i_score >= w_thresh) & w_cap_ok;
  assign w_push       = w_accept & (~w_full | w_pop);
  assign w_drop       = w_accept & w_full & ~w_pop;

  key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_in_key),
    .o_dout  (w_head_key),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Frame controller: state, marker flag, accepted-key count and sticky overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_last     <= 1'b0;
      r_key_cnt  <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_last <= 1'b0;
          if (i_frame_start) begin
            r_state    <= COLLECT;
            r_key_cnt  <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        COLLECT: begin
          r_last <= 1'b0;
          if (!i_frame_end && i_frame_start) begin
            // Restart: counters clear, but a key accepted this cycle still counts.
            r_state    <= COLLECT;
            r_key_cnt  <= w_push ? CNT_W'(1) : {CNT_W{1'b0}};
            r_overflow <= w_drop;
          end else begin
            r_state <= i_frame_end ? FLUSH : COLLECT;
            if (w_push) begin
              r_key_cnt <= r_key_cnt + CNT_W'(1);
            end else begin
              r_key_cnt <= r_key_cnt;
            end
            if (w_drop) begin
              r_overflow <= 1'b1;
            end else begin
              r_overflow <= r_overflow;
            end
          end
        end
        FLUSH: begin
          if (w_empty) begin
            r_state <= MARK;
            r_last  <= 1'b1;
          end else begin
            r_state <= FLUSH;
            r_last  <= 1'b0;
          end
        end
        MARK: begin
          if (i_ready) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
          end else begin
            r_state <= MARK;
            r_last  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  // Output beat data: the FIFO head while it holds a record, zeros otherwise
  // (which is also the payload of the end-of-frame marker).
  always_comb begin
    w_out_key = key_t'({KEY_W{1'b0}});
    if (w_fifo_valid) begin
      w_out_key = w_head_key;
    end else begin
      w_out_key = key_t'({KEY_W{1'b0}});
    end
  end

  assign o_valid    = w_fifo_valid | r_last;
  assign o_last     = r_last;
  assign o_sin      = w_out_key.sin;
  assign o_cos      = w_out_key.cos;
  assign o_coor_x   = w_out_key.x;
  assign o_coor_y   = w_out_key.y;
  assign o_score    = w_out_key.score;
  assign o_key_cnt  = r_key_cnt;
  assign o_overflow = r_overflow;

endmodule
